temp_to_vtherm: RTL



---
 rtl/temp_to_vtherm.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/temp_to_vtherm.sv
`default_nettype none
// ============================================================================
// Module   : temp_to_vtherm
// Purpose  : Inverse thermistor model. Takes a requested temperature (integer
//            degrees C) and returns the smallest 4-bit voltage code whose
//            table temperature is at or below the request. The result comes
//            from a 4-step successive-approximation search over a fixed
//            16-entry, strictly decreasing temperature ROM.
// Ports    : clk         - sole clock, rising edge
//            rst_n       - synchronous active-low reset
//            temp_therm  - requested temperature [TW-1:0], sampled on accept
//            in_valid    - request valid
//            in_ready    - block can accept a request (registered)
//            v_therm     - resulting voltage code [3:0] (registered)
//            exact       - table[v_therm] equals the request (registered)
//            sat         - request above table[0], code clamped to 0
//            out_valid   - result valid (registered)
//            out_ready   - consumer takes the result
// Revision : 1.0 - initial release
// ============================================================================
module temp_to_vtherm #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] temp_therm,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    v_therm,
    output logic          exact,
    output logic          sat,
    output logic          out_valid,
    input  logic          out_ready
);

    // Hottest table entry; anything above it saturates to code 0.
    localparam logic [6:0] c_T_MAX = 7'd120;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_FIX    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Forward model: voltage code -> temperature, strictly decreasing.
    function automatic logic [6:0] rom_temp(input logic [3:0] code);
        logic [6:0] t;
        case (code)
            4'd0:    t = 7'd120;
            4'd1:    t = 7'd100;
            4'd2:    t = 7'd88;
            4'd3:    t = 7'd79;
            4'd4:    t = 7'd72;
            4'd5:    t = 7'd66;
            4'd6:    t = 7'd60;
            4'd7:    t = 7'd55;
            4'd8:    t = 7'd50;
            4'd9:    t = 7'd45;
            4'd10:   t = 7'd40;
            4'd11:   t = 7'd35;
            4'd12:   t = 7'd29;
            4'd13:   t = 7'd22;
            4'd14:   t = 7'd13;
            default: t = 7'd0;
        endcase
        return t;
    endfunction

    state_t        r_state;
    logic [TW-1:0] r_temp;
    logic [3:0]    r_code;
    logic [1:0]    r_bit;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [3:0]    r_v_therm;
    logic          r_exact;
    logic          r_sat;

    logic [3:0]    w_cand;
    logic          w_cand_gt;
    logic          w_code_gt;
    logic [3:0]    w_result;
    logic          w_result_eq;
    logic          w_sat;

    // The search converges on the largest code whose table entry is still
    // hotter than the request (or 0 if none is). The answer is then either
    // that code or the next one, which FIX decides with one more compare.
    always_comb begin
        w_cand      = r_code | (4'd1 << r_bit);
        w_cand_gt   = TW'(rom_temp(w_cand)) > r_temp;
        w_code_gt   = TW'(rom_temp(r_code)) > r_temp;
        // r_code is at most 14 when w_code_gt holds (table[15] is 0), so the
        // increment cannot wrap.
        w_result    = w_code_gt ? (r_code + 4'd1) : r_code;
        w_result_eq = TW'(rom_temp(w_result)) == r_temp;
        w_sat       = r_temp > TW'(c_T_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_temp      <= '0;
            r_code      <= 4'd0;
            r_bit       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_v_therm   <= 4'd0;
            r_exact     <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_temp     <= temp_therm;
                        r_code     <= 4'd0;
                        r_bit      <= 2'd3;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_cand_gt) begin
                        r_code <= w_cand;
                    end
                    if (r_bit == 2'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_bit <= r_bit - 2'd1;
                    end
                end
                S_FIX: begin
                    r_v_therm   <= w_result;
                    r_exact     <= w_result_eq;
                    r_sat       <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    // Result registers stay untouched until the next FIX.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign v_therm   = r_v_therm;
    assign exact     = r_exact;
    assign sat       = r_sat;

endmodule
`default_nettype wire
